// File: rtl/pipeline_controller.sv
// ----------------------------------------------------------------------------
// pipeline_controller: PC/stage-enable sequencer for the 3-stage RV32I core.
// Optional macro PIPELINE_PERF_CTR_EN adds cycle/stall counters.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_controller #(
  parameter int FINAL_PC = 18,
  parameter int PC_W     = 32
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            RUN,
  input  logic            CONDITIONAL_JUMP,
  input  logic            JUMP_VALID,
  input  logic [PC_W-1:0] JUMP_DEST,
  input  logic            LOAD_USE_HAZARD,
  input  logic [PC_W-1:0] WB_PC,
  output logic [PC_W-1:0] PC,
  output logic            FETCH_VALID,
  output logic            DECODER_ENABLED,
  output logic            EXECUTER_ENABLED,
  output logic            WRITER_ENABLED,
  output logic            COMPLETED,
  output logic [1:0]      STATE,
  output logic [31:0]     CYCLE_COUNT,
  output logic [31:0]     STALL_COUNT
);

  // DONE shares the externally visible code 0 with IDLE; bit 2 tells them apart.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_RUN     = 3'b001,
    S_BR_EXEC = 3'b010,
    S_BR_WB   = 3'b011,
    S_DONE    = 3'b100
  } state_t;

  localparam logic [PC_W:0]   LAST_IDX = (PC_W+1)'(FINAL_PC);
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

  state_t          state;
  logic [PC_W-1:0] pc_inc;
  logic            pc_fetchable;
  logic            inc_fetchable;
  logic            wb_past_end;

  assign pc_inc        = PC + PC_ONE;
  assign pc_fetchable  = ({1'b0, PC} <= LAST_IDX);
  assign inc_fetchable = ({1'b0, pc_inc} <= LAST_IDX);
  assign wb_past_end   = ({1'b0, WB_PC} > LAST_IDX);
  assign STATE         = state[1:0];

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state            <= S_IDLE;
      PC               <= '0;
      FETCH_VALID      <= 1'b0;
      DECODER_ENABLED  <= 1'b0;
      EXECUTER_ENABLED <= 1'b0;
      WRITER_ENABLED   <= 1'b0;
      COMPLETED        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          PC <= '0;
          if (RUN) begin
            state            <= S_RUN;
            FETCH_VALID      <= 1'b1;
            DECODER_ENABLED  <= 1'b1;
            EXECUTER_ENABLED <= 1'b1;
            WRITER_ENABLED   <= 1'b1;
          end
        end

        S_RUN: begin
          if (wb_past_end) begin
            state            <= S_DONE;
            FETCH_VALID      <= 1'b0;
            DECODER_ENABLED  <= 1'b0;
            EXECUTER_ENABLED <= 1'b0;
            WRITER_ENABLED   <= 1'b0;
            COMPLETED        <= 1'b1;
          end else if (CONDITIONAL_JUMP) begin
            // A concurrent load-use hazard is dropped: the branch flushes decode anyway.
            state           <= S_BR_EXEC;
            DECODER_ENABLED <= 1'b0;
            FETCH_VALID     <= 1'b0;
          end else if (LOAD_USE_HAZARD) begin
            DECODER_ENABLED <= 1'b0;
            FETCH_VALID     <= pc_fetchable;
          end else begin
            PC              <= pc_inc;
            DECODER_ENABLED <= 1'b1;
            FETCH_VALID     <= inc_fetchable;
          end
        end

        S_BR_EXEC: begin
          if (wb_past_end) begin
            state            <= S_DONE;
            FETCH_VALID      <= 1'b0;
            DECODER_ENABLED  <= 1'b0;
            EXECUTER_ENABLED <= 1'b0;
            WRITER_ENABLED   <= 1'b0;
            COMPLETED        <= 1'b1;
          end else if (JUMP_VALID) begin
            state <= S_BR_WB;
            PC    <= JUMP_DEST;
          end
        end

        S_BR_WB: begin
          state           <= S_RUN;
          PC              <= pc_inc;
          DECODER_ENABLED <= 1'b1;
          FETCH_VALID     <= inc_fetchable;
        end

        S_DONE: begin
          state <= S_DONE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PIPELINE_PERF_CTR_EN
  logic busy;

  assign busy = (state == S_RUN) || (state == S_BR_EXEC) || (state == S_BR_WB);

  // Both counters saturate rather than wrap so long runs never read as short ones.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      CYCLE_COUNT <= '0;
      STALL_COUNT <= '0;
    end else if (busy) begin
      if (CYCLE_COUNT != 32'hFFFF_FFFF) begin
        CYCLE_COUNT <= CYCLE_COUNT + 32'd1;
      end
      if (!DECODER_ENABLED && (STALL_COUNT != 32'hFFFF_FFFF)) begin
        STALL_COUNT <= STALL_COUNT + 32'd1;
      end
    end
  end
`else
  assign CYCLE_COUNT = '0;
  assign STALL_COUNT = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_controller.md
# pipeline_controller

Central sequencer for the 3-stage RV32I core (fetch/decode, execute, write-back). It replaces the ad hoc stall logic in the top level. It owns the word-indexed program counter and the per-stage enables, and handles three events: branch/jump redirection, single-cycle load-use stalls, and end-of-program detection. It sits between the decoder/executer hazard outputs and the instruction fetch, decode and write-back enables.

## Interface
- `FINAL_PC`, 18: word index of the last program instruction.
- `PC_W`, 32: width of the PC and of the jump destination.
- `CLK` in 1: clock, rising edge.
- `RSTN` in 1: reset, synchronous, active-low.
- `RUN` in 1: start request; sampled only in IDLE.
- `CONDITIONAL_JUMP` in 1: the decode stage holds a branch or jump.
- `JUMP_VALID` in 1: the executer has resolved the branch; `JUMP_DEST` is valid.
- `JUMP_DEST` in PC_W: resolved target word index, or the fall-through index if the branch is not taken.
- `LOAD_USE_HAZARD` in 1: a load is in execute and the decode-stage instruction consumes its rd.
- `WB_PC` in PC_W: PC of the instruction in the write-back stage (`ctr_info_e.pc`).
- `PC` out PC_W: fetch address.
- `FETCH_VALID` out 1: 1 = fetch `inst_mem[PC]`; 0 = inject NOP (0x00000013).
- `DECODER_ENABLED`, `EXECUTER_ENABLED`, `WRITER_ENABLED` out 1 each: stage enables.
- `COMPLETED` out 1: sticky program-done flag.
- `STATE` out 2: IDLE=0, RUN=1, BR_EXEC=2, BR_WB=3; DONE is encoded as 0 with `COMPLETED`=1.
- `CYCLE_COUNT`, `STALL_COUNT` out 32: performance counters (see Configuration).

## Operation
- All outputs are registered.
- Reset (RSTN=0 at a rising edge) sets: PC=0, all enables=0, FETCH_VALID=0, COMPLETED=0, STATE=IDLE, counters=0.
- Reset applies from any state, including mid-branch, and takes effect on the next edge.
- IDLE:
  - PC holds 0 and all enables are 0.
  - RUN=1 → RUN state; all enables=1, FETCH_VALID=1.
- RUN: each cycle, evaluate in priority order:
  1. WB_PC ≥ FINAL_PC+1 → DONE. Enables=0, FETCH_VALID=0, COMPLETED=1. PC holds.
  2. CONDITIONAL_JUMP=1 → BR_EXEC. DECODER_ENABLED=0, PC holds, FETCH_VALID=0.
  3. LOAD_USE_HAZARD=1 → stay in RUN. PC holds and DECODER_ENABLED=0 for exactly that cycle; the next cycle re-enables it.
  4. Otherwise PC ← PC+1.
- BR_EXEC:
  - Wait for JUMP_VALID=1, holding indefinitely.
  - On JUMP_VALID=1: PC ← JUMP_DEST, → BR_WB.
  - The completion check remains active in BR_EXEC.
- BR_WB:
  - DECODER_ENABLED=1, FETCH_VALID=1, PC ← PC+1, → RUN.
- DONE:
  - Terminal state; all outputs hold.
  - Left only by reset. RUN is ignored.
- EXECUTER_ENABLED and WRITER_ENABLED are 1 in RUN, BR_EXEC and BR_WB, so a branch drains through execute and write-back.
- PC arithmetic is modulo 2^PC_W; wrap is not flagged.
- JUMP_VALID outside BR_EXEC is ignored.
- FETCH_VALID=0 whenever PC > FINAL_PC.

## Timing
- Fetch uses the registered PC from the same cycle. The instruction is captured at the next edge.
- Branch penalty: CONDITIONAL_JUMP sampled at edge N → BR_EXEC at N. PC=JUMP_DEST at N+1 at the earliest. RUN at N+2. That is 2 bubble cycles minimum, plus one cycle per cycle JUMP_VALID is late.
- Load-use stall: 1 bubble per assertion. Back-to-back assertions give back-to-back stalls.
- Simultaneous CONDITIONAL_JUMP and LOAD_USE_HAZARD: the branch wins; the hazard is dropped.
- Simultaneous completion and branch: completion wins.
- COMPLETED rises one edge after WB_PC first reaches FINAL_PC+1.

## Configuration
- `PIPELINE_PERF_CTR_EN` defined:
  - CYCLE_COUNT increments every cycle outside IDLE and DONE.
  - STALL_COUNT increments every cycle DECODER_ENABLED=0 while in RUN, BR_EXEC or BR_WB.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

## Test plan
- Reset then RUN=1 for 1 cycle, no hazards → PC steps 0,1,2,… one per cycle; all enables=1 one edge after RUN.
- CONDITIONAL_JUMP at PC=4, JUMP_VALID with JUMP_DEST=5 one cycle later → DECODER_ENABLED low for 2 cycles, PC sequence 4,4,5,6; STATE 1→2→3→1.
- Same as above with JUMP_VALID delayed 3 cycles → BR_EXEC held 3 extra cycles, PC held at 4, STALL_COUNT=5 (macro on).
- LOAD_USE_HAZARD for 1 cycle at PC=7 → PC 7,7,8; DECODER_ENABLED low for exactly one cycle.
- WB_PC=19 with FINAL_PC=18, concurrent CONDITIONAL_JUMP → COMPLETED=1 next edge, enables=0, PC frozen, STATE stays in DONE despite RUN=1.
- RSTN=0 while in BR_EXEC → next edge: PC=0, STATE=IDLE, COMPLETED=0, counters=0.
